// File: rtl/kernel_end_dumper.sv
// kernel_end_dumper: detects kernel end or watchdog expiry, then streams a data memory window to the host
module kernel_end_dumper #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int STATE_W   = 5,
  parameter int END_STATE = 19,
  parameter int DUMP_BASE = 0,
  parameter int DUMP_LEN  = 32,
  parameter int TIMEOUT   = 4096,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [STATE_W-1:0] cu_state,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_index,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);
  localparam logic [2:0] RUN = 3'd0, READ = 3'd1, WAIT = 3'd2, SEND = 3'd3, DONE = 3'd4;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DUMP_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(DUMP_BASE);
  localparam logic [CNT_W-1:0]  WD_LIMIT = CNT_W'(TIMEOUT - 1);
  logic [2:0]        state;
  logic [ADDR_W-1:0] offset;
  logic              end_hit, wd_hit;
  assign end_hit     = cu_state == STATE_W'(END_STATE);
  assign wd_hit      = (TIMEOUT != 0) && (cycle_count == WD_LIMIT);
  assign mem_rd_en   = state == READ;
  assign mem_rd_addr = mem_rd_en ? BASE + offset : '0;
  assign dump_valid  = state == SEND;
  assign busy        = (state == READ) || (state == WAIT) || (state == SEND);
  assign done        = state == DONE;
  // Trigger detection, cycle counting and the read/wait/send walk over the window
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      offset      <= '0;
      dump_data   <= '0;
      dump_index  <= '0;
      dump_last   <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        RUN:
          if (end_hit || wd_hit) begin
            state   <= READ;
            timeout <= !end_hit;
          end else if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
        READ: state <= WAIT;
        WAIT: begin
          dump_data  <= mem_rd_data;
          dump_index <= offset;
          dump_last  <= offset == LAST;
          state      <= SEND;
        end
        SEND:
          if (dump_ready) begin
            state  <= dump_last ? DONE : READ;
            offset <= offset + ADDR_W'(1);
          end
        default: state <= DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_kernel_end_dumper.sv
// tb_kernel_end_dumper: directed checks of trigger, streaming, backpressure, watchdog, wrap and reset
module tb_kernel_end_dumper;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dump_ready = 1'b1;
  logic [4:0]  cs[3];
  logic        re[3], dv[3], dl[3], by[3], dn[3], to[3];
  logic [7:0]  ra[3], di[3];
  logic [15:0] rd[3], dd[3], cc[3];
  int          rdc[3];
  int          checks = 0;
  int          errors = 0;
  int          el;

  always #5 clk = ~clk;

  kernel_end_dumper u0 (
    .clk(clk), .reset(reset), .cu_state(cs[0]), .mem_rd_en(re[0]), .mem_rd_addr(ra[0]),
    .mem_rd_data(rd[0]), .dump_valid(dv[0]), .dump_ready(dump_ready), .dump_data(dd[0]),
    .dump_index(di[0]), .dump_last(dl[0]), .busy(by[0]), .done(dn[0]), .timeout(to[0]),
    .cycle_count(cc[0]));

  kernel_end_dumper #(.TIMEOUT(50), .DUMP_LEN(4)) u1 (
    .clk(clk), .reset(reset), .cu_state(cs[1]), .mem_rd_en(re[1]), .mem_rd_addr(ra[1]),
    .mem_rd_data(rd[1]), .dump_valid(dv[1]), .dump_ready(dump_ready), .dump_data(dd[1]),
    .dump_index(di[1]), .dump_last(dl[1]), .busy(by[1]), .done(dn[1]), .timeout(to[1]),
    .cycle_count(cc[1]));

  kernel_end_dumper #(.DUMP_BASE(250), .DUMP_LEN(10)) u2 (
    .clk(clk), .reset(reset), .cu_state(cs[2]), .mem_rd_en(re[2]), .mem_rd_addr(ra[2]),
    .mem_rd_data(rd[2]), .dump_valid(dv[2]), .dump_ready(dump_ready), .dump_data(dd[2]),
    .dump_index(di[2]), .dump_last(dl[2]), .busy(by[2]), .done(dn[2]), .timeout(to[2]),
    .cycle_count(cc[2]));

  // Synchronous memories holding RAM[a] = a*3, plus a read-strobe counter per instance
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (re[i]) rd[i] <= 16'(ra[i]) * 16'd3;
      rdc[i] <= reset ? 0 : rdc[i] + int'(re[i]);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs(input int k);
    return 64'({re[k], ra[k], dv[k], dd[k], di[k], dl[k], by[k], dn[k], to[k], cc[k]});
  endfunction

  task automatic start();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_dump(input int k, input int base, input int n, input int stall,
                          input int stop, output int elapsed);
    int j;
    int r0;
    j = 0;
    elapsed = 0;
    while (j < n) begin
      @(negedge clk);
      elapsed++;
      if (elapsed > 1000) begin
        chk("dump_bound", 64'(j), 64'(n));
        return;
      end
      if (re[k]) chk("rd_addr", 64'(ra[k]), 64'((base + j) % 256));
      if (dv[k]) begin
        chk("data", 64'(dd[k]), 64'(((base + j) % 256) * 3));
        chk("index", 64'(di[k]), 64'(j));
        chk("last", 64'(dl[k]), 64'(j == n - 1));
        if (j == stop) return;
        if (j == stall) begin
          dump_ready = 1'b0;
          r0 = rdc[k];
          repeat (5) begin
            @(negedge clk);
            elapsed++;
            chk("stall_valid", 64'(dv[k]), 64'(1));
            chk("stall_data", 64'(dd[k]), 64'(((base + j) % 256) * 3));
            chk("stall_index", 64'(di[k]), 64'(j));
          end
          chk("stall_reads", 64'(rdc[k]), 64'(r0));
          dump_ready = 1'b1;
        end
        j++;
      end
    end
    @(negedge clk);
    elapsed++;
    chk("done", 64'(dn[k]), 64'(1));
    chk("valid_drop", 64'(dv[k]), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cs[i] = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs(0), 64'(0));
    // END trigger at cycle 100, full dump at full rate
    start();
    repeat (100) @(negedge clk);
    chk("t1_pre_count", 64'(cc[0]), 64'(100));
    chk("t1_pre_busy", 64'(by[0]), 64'(0));
    cs[0] = 5'd19;
    run_dump(0, 0, 32, -1, -1, el);
    chk("t1_elapsed", 64'(el), 64'(97));
    chk("t1_timeout", 64'(to[0]), 64'(0));
    chk("t1_count", 64'(cc[0]), 64'(100));
    chk("t1_busy", 64'(by[0]), 64'(0));
    chk("t1_reads", 64'(rdc[0]), 64'(32));
    cs[0] = 5'd0;
    repeat (3) @(negedge clk);
    chk("t1_sticky", 64'(dn[0]), 64'(1));
    // Backpressure on word 7
    start();
    repeat (100) @(negedge clk);
    cs[0] = 5'd19;
    run_dump(0, 0, 32, 7, -1, el);
    chk("t2_elapsed", 64'(el), 64'(102));
    chk("t2_reads", 64'(rdc[0]), 64'(32));
    // Reset in the middle of the dump, then restart
    cs[0] = 5'd0;
    start();
    repeat (10) @(negedge clk);
    cs[0] = 5'd19;
    run_dump(0, 0, 32, -1, 12, el);
    reset = 1'b1;
    cs[0] = 5'd0;
    @(negedge clk);
    chk("t6_reset_outs", outs(0), 64'(0));
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_count", 64'(cc[0]), 64'(5));
    chk("t6_idle", 64'(by[0]), 64'(0));
    cs[0] = 5'd19;
    run_dump(0, 0, 32, -1, -1, el);
    chk("t6_elapsed", 64'(el), 64'(97));
    // Watchdog trigger
    start();
    run_dump(1, 0, 4, -1, -1, el);
    chk("t3_elapsed", 64'(el), 64'(62));
    chk("t3_timeout", 64'(to[1]), 64'(1));
    chk("t3_count", 64'(cc[1]), 64'(49));
    // END coincides with watchdog expiry
    start();
    repeat (49) @(negedge clk);
    chk("t4_pre_count", 64'(cc[1]), 64'(49));
    cs[1] = 5'd19;
    run_dump(1, 0, 4, -1, -1, el);
    chk("t4_elapsed", 64'(el), 64'(13));
    chk("t4_timeout", 64'(to[1]), 64'(0));
    chk("t4_count", 64'(cc[1]), 64'(49));
    // Window wrapping past the top of the address space
    cs[1] = 5'd0;
    start();
    repeat (3) @(negedge clk);
    cs[2] = 5'd19;
    run_dump(2, 250, 10, -1, -1, el);
    chk("t5_elapsed", 64'(el), 64'(31));
    chk("t5_reads", 64'(rdc[2]), 64'(10));
    chk("t5_timeout", 64'(to[2]), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kernel_end_dumper.md
Name: kernel_end_dumper

Overview:
Synthesizable end-of-kernel monitor for the SM core.
- Watches the scheduler CU state and detects kernel completion, or a watchdog timeout.
- Then walks a parametrised window of data memory through a synchronous read port and streams each word out on a valid/ready channel for host readback.
- Sits beside DataMemory in System, sharing its read port while the core is halted.

Parameters:
DATA_W, 16, data memory word width
ADDR_W, 8, data memory address width
STATE_W, 5, CU state encoding width
END_STATE, 19, CU state value meaning kernel finished
DUMP_BASE, 0, first dumped address
DUMP_LEN, 32, number of words dumped; must be >= 1
TIMEOUT, 4096, watchdog limit in cycles; 0 disables the watchdog
CNT_W, 16, cycle counter width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
cu_state  in  STATE_W  current CU state from Scheduler
mem_rd_en  out  1  data memory read strobe
mem_rd_addr  out  ADDR_W  data memory read address
mem_rd_data  in  DATA_W  read data, valid one cycle after mem_rd_en
dump_valid  out  1  dump word available
dump_ready  in  1  consumer accepts word
dump_data  out  DATA_W  dumped word
dump_index  out  ADDR_W  offset of word within window, 0..DUMP_LEN-1
dump_last  out  1  high with the final word
busy  out  1  dump in progress
done  out  1  dump complete, sticky
timeout  out  1  dump was triggered by the watchdog, sticky
cycle_count  out  CNT_W  cycles from reset release to trigger

Behaviour:
- Reset (synchronous): state RUN; all outputs 0; internal offset 0. Reset mid-dump aborts the dump, and every output reads 0 on the cycle after the reset edge.
- States: RUN -> READ -> WAIT -> SEND -> (READ | DONE). Moore outputs only.
- RUN:
  - cycle_count increments every cycle and saturates at all-ones.
  - The trigger is sampled at each edge.
  - If cu_state == END_STATE: go to READ with timeout = 0.
  - Else if TIMEOUT != 0 and cycle_count == TIMEOUT-1: go to READ and set timeout = 1.
  - If both conditions hold in the same cycle, END wins and timeout = 0.
  - cycle_count freezes at trigger.
- READ:
  - mem_rd_en = 1, mem_rd_addr = (DUMP_BASE + offset) mod 2^ADDR_W, busy = 1.
  - Always proceeds to WAIT.
- WAIT:
  - mem_rd_en = 0.
  - mem_rd_data is captured into dump_data at the end of the cycle.
  - dump_index <= offset; dump_last <= (offset == DUMP_LEN-1).
  - Proceeds to SEND.
- SEND:
  - dump_valid = 1.
  - dump_data, dump_index and dump_last are held stable while dump_valid && !dump_ready.
  - On dump_ready: if dump_last, go to DONE; else offset++ and go to READ.
  - dump_valid drops the cycle after acceptance.
- DONE:
  - done = 1, busy = 0, dump_valid = 0, mem_rd_en = 0.
  - Stays in DONE until reset.
- Trigger timing: first dump_valid is the third cycle after the trigger edge (READ, WAIT, SEND).
- Throughput: minimum 3 cycles per word with dump_ready held high. A full dump takes exactly 3*DUMP_LEN cycles from trigger to the DONE entry edge.
- cu_state is ignored outside RUN. Leaving END_STATE after the trigger has no effect.
- Address wrap: an address past 2^ADDR_W-1 wraps to 0. No error is flagged.
- DUMP_LEN = 1: the first word carries dump_last = 1.
- cycle_count is not cleared by the dump and is readable in DONE.

Test Plan:
1. Default params. Drive cu_state = 19 at cycle 100; memory holds RAM[i] = i*3; dump_ready = 1. Required: 32 words 0,3,...,93 with dump_index 0..31; dump_last only on index 31; done rises 96 cycles after trigger; timeout = 0; cycle_count = 100.
2. Backpressure: dump_ready low for 5 cycles on word 7. Required: dump_valid, dump_data = 21 and dump_index = 7 all held; no extra mem_rd_en pulses; word 8 follows normally.
3. Watchdog: TIMEOUT = 50, cu_state never 19. Required: trigger at cycle_count = 49; timeout = 1; full dump completes; done = 1.
4. Simultaneous trigger: TIMEOUT = 50, cu_state = 19 exactly when cycle_count = 49. Required: timeout = 0, dump proceeds.
5. Wrap: DUMP_BASE = 250, DUMP_LEN = 10, ADDR_W = 8. Required: read addresses 250..255, then 0..3; dump_index 0..9.
6. Reset mid-dump: assert reset at word 12. Required: all outputs 0 next cycle. A new cu_state = 19 then restarts the dump from dump_index 0.
